// File: rtl/ibex_mem_arbiter.sv
// Two-host (instruction fetch / LSU) arbiter onto one request/grant/rvalid memory port.
// Keeps the request stable until it is granted and returns each response to the host that issued it, in issue order.
module ibex_mem_arbiter #(
   parameter int unsigned MaxOutstanding = 2,
   parameter bit          DataPriority   = 1'b1,
   parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,

   input  logic            instr_req_i,
   output logic            instr_gnt_o,
   output logic            instr_rvalid_o,
   input  logic [31:0]     instr_addr_i,
   output logic [31:0]     instr_rdata_o,
   output logic [6:0]      instr_rdata_intg_o,
   output logic            instr_err_o,

   input  logic            data_req_i,
   output logic            data_gnt_o,
   output logic            data_rvalid_o,
   input  logic            data_we_i,
   input  logic [3:0]      data_be_i,
   input  logic [31:0]     data_addr_i,
   input  logic [31:0]     data_wdata_i,
   input  logic [6:0]      data_wdata_intg_i,
   output logic [31:0]     data_rdata_o,
   output logic [6:0]      data_rdata_intg_o,
   output logic            data_err_o,

   output logic            bus_req_o,
   input  logic            bus_gnt_i,
   input  logic            bus_rvalid_i,
   output logic            bus_we_o,
   output logic [3:0]      bus_be_o,
   output logic [31:0]     bus_addr_o,
   output logic [31:0]     bus_wdata_o,
   output logic [6:0]      bus_wdata_intg_o,
   input  logic [31:0]     bus_rdata_i,
   input  logic [6:0]      bus_rdata_intg_i,
   input  logic            bus_err_i,

   output logic [CntW-1:0] outstanding_o,
   output logic            protocol_err_o
);

   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

   localparam logic [0:0] StIdle   = 1'b0;
   localparam logic [0:0] StLocked = 1'b1;

   localparam logic HostInstr = 1'b0;
   localparam logic HostData  = 1'b1;

   logic [0:0]      state_reg;
   logic [0:0]      state_next;
   logic            owner_reg;
   logic            owner_next;
   logic            last_winner_reg;
   logic            last_winner_next;
   logic [PtrW-1:0] wr_ptr_reg;
   logic [PtrW-1:0] wr_ptr_next;
   logic [PtrW-1:0] rd_ptr_reg;
   logic [PtrW-1:0] rd_ptr_next;
   logic [CntW-1:0] count_reg;
   logic [CntW-1:0] count_next;
   logic            protocol_err_reg;
   logic            protocol_err_next;

   logic [MaxOutstanding-1:0] id_vec;

   logic sel_valid;
   logic sel_data;
   logic fifo_full;
   logic fifo_empty;
   logic push;
   logic pop;
   logic head_id;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      if (ptr == PtrW'(MaxOutstanding - 1)) begin
         return '0;
      end
      return ptr + PtrW'(1);
   endfunction

   assign fifo_full  = (count_reg == CntW'(MaxOutstanding));
   assign fifo_empty = (count_reg == '0);

   // New winners are only picked from IDLE; once LOCKED the owner keeps the bus until granted or it withdraws.
   always_comb begin
      sel_valid = 1'b0;
      sel_data  = HostInstr;
      if (state_reg == StLocked) begin
         sel_data  = owner_reg;
         sel_valid = (owner_reg == HostData) ? data_req_i : instr_req_i;
      end else if (!fifo_full) begin
         if (data_req_i && instr_req_i) begin
            sel_valid = 1'b1;
            if (DataPriority) begin
               sel_data = HostData;
            end else begin
               sel_data = (last_winner_reg == HostInstr) ? HostData : HostInstr;
            end
         end else if (data_req_i) begin
            sel_valid = 1'b1;
            sel_data  = HostData;
         end else if (instr_req_i) begin
            sel_valid = 1'b1;
            sel_data  = HostInstr;
         end
      end
   end

   assign push = sel_valid & bus_gnt_i;
   assign pop  = bus_rvalid_i & ~fifo_empty;

   always_comb begin
      state_next       = state_reg;
      owner_next       = owner_reg;
      last_winner_next = last_winner_reg;
      if (push) begin
         last_winner_next = sel_data;
      end
      if (state_reg == StIdle) begin
         if (sel_valid && !bus_gnt_i) begin
            state_next = StLocked;
            owner_next = sel_data;
         end
      end else begin
         if (push || !sel_valid) begin
            state_next = StIdle;
         end
      end
   end

   always_comb begin
      wr_ptr_next       = wr_ptr_reg;
      rd_ptr_next       = rd_ptr_reg;
      count_next        = count_reg;
      protocol_err_next = protocol_err_reg;
      if (push) begin
         wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
         rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      if (push && !pop) begin
         count_next = count_reg + CntW'(1);
      end else if (pop && !push) begin
         count_next = count_reg - CntW'(1);
      end
      if (bus_rvalid_i && fifo_empty) begin
         protocol_err_next = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg        <= StIdle;
         owner_reg        <= HostInstr;
         last_winner_reg  <= HostInstr;
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         count_reg        <= '0;
         protocol_err_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         owner_reg        <= owner_next;
         last_winner_reg  <= last_winner_next;
         wr_ptr_reg       <= wr_ptr_next;
         rd_ptr_reg       <= rd_ptr_next;
         count_reg        <= count_next;
         protocol_err_reg <= protocol_err_next;
      end
   end

   // One host-ID flop per order-FIFO slot.
   for (genvar gi = 0; gi < MaxOutstanding; gi++) begin : g_order
      logic entry_reg;
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            entry_reg <= HostInstr;
         end else if (push && (wr_ptr_reg == PtrW'(gi))) begin
            entry_reg <= sel_data;
         end
      end
      assign id_vec[gi] = entry_reg;
   end

   assign head_id = id_vec[rd_ptr_reg];

   always_comb begin
      bus_we_o         = 1'b0;
      bus_be_o         = 4'h0;
      bus_addr_o       = 32'h0;
      bus_wdata_o      = 32'h0;
      bus_wdata_intg_o = 7'h0;
      if (sel_valid) begin
         if (sel_data == HostData) begin
            bus_we_o         = data_we_i;
            bus_be_o         = data_be_i;
            bus_addr_o       = data_addr_i;
            bus_wdata_o      = data_wdata_i;
            bus_wdata_intg_o = data_wdata_intg_i;
         end else begin
            bus_be_o   = 4'hF;
            bus_addr_o = instr_addr_i;
         end
      end
   end

   assign bus_req_o   = sel_valid;
   assign instr_gnt_o = push & (sel_data == HostInstr);
   assign data_gnt_o  = push & (sel_data == HostData);

   assign instr_rvalid_o = pop & (head_id == HostInstr);
   assign data_rvalid_o  = pop & (head_id == HostData);
   assign instr_err_o    = bus_err_i & instr_rvalid_o;
   assign data_err_o     = bus_err_i & data_rvalid_o;

   assign instr_rdata_o      = bus_rdata_i;
   assign instr_rdata_intg_o = bus_rdata_intg_i;
   assign data_rdata_o       = bus_rdata_i;
   assign data_rdata_intg_o  = bus_rdata_intg_i;

   assign outstanding_o  = count_reg;
   assign protocol_err_o = protocol_err_reg;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Bench for ibex_mem_arbiter: instance 0 uses data priority, instance 1 round-robin, both on shared stimulus.
// A queue-level model is checked every cycle; directed literal checks pin the key scenarios.
module tb_ibex_mem_arbiter;

   localparam int MAXO = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        instr_req = 0;
   logic [31:0] instr_addr = 0;
   logic        data_req = 0, data_we = 0;
   logic [3:0]  data_be = 0;
   logic [31:0] data_addr = 0, data_wdata = 0;
   logic [6:0]  data_wintg = 0;
   logic        bus_gnt = 0, bus_rvalid = 0, bus_err = 0;
   logic [31:0] bus_rdata = 0;
   logic [6:0]  bus_rintg = 0;

   logic [1:0]  instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err;
   logic [1:0]  bus_req, bus_we, perr;
   logic [3:0]  bus_be [2];
   logic [31:0] bus_addr [2], bus_wdata [2], instr_rdata [2], data_rdata [2];
   logic [6:0]  bus_wintg [2], instr_rintg [2], data_rintg [2];
   logic [1:0]  outst [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      ibex_mem_arbiter #(
         .MaxOutstanding(MAXO),
         .DataPriority((gi == 0) ? 1'b1 : 1'b0)
      ) dut (
         .clk_i(clk), .rst_i(rst),
         .instr_req_i(instr_req), .instr_gnt_o(instr_gnt[gi]), .instr_rvalid_o(instr_rvalid[gi]),
         .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata[gi]),
         .instr_rdata_intg_o(instr_rintg[gi]), .instr_err_o(instr_err[gi]),
         .data_req_i(data_req), .data_gnt_o(data_gnt[gi]), .data_rvalid_o(data_rvalid[gi]),
         .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
         .data_wdata_i(data_wdata), .data_wdata_intg_i(data_wintg),
         .data_rdata_o(data_rdata[gi]), .data_rdata_intg_o(data_rintg[gi]), .data_err_o(data_err[gi]),
         .bus_req_o(bus_req[gi]), .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid),
         .bus_we_o(bus_we[gi]), .bus_be_o(bus_be[gi]), .bus_addr_o(bus_addr[gi]),
         .bus_wdata_o(bus_wdata[gi]), .bus_wdata_intg_o(bus_wintg[gi]),
         .bus_rdata_i(bus_rdata), .bus_rdata_intg_i(bus_rintg), .bus_err_i(bus_err),
         .outstanding_o(outst[gi]), .protocol_err_o(perr[gi])
      );
   end

   int total = 0;
   int bad = 0;
   bit chk_en = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model state per instance: list of outstanding host IDs (1=data), held owner, last winner.
   bit m_locked [2], m_owner [2], m_last [2], m_perr [2];
   bit m_q [2][4];
   int m_cnt [2];

   initial begin
      bit cv, cd, gnt, has, irv, drv, ew;
      bit [3:0] ebe;
      bit [31:0] eaddr, ewd;
      bit [6:0] eint;
      string p;
      for (int m = 0; m < 2; m++) begin
         m_locked[m] = 0; m_owner[m] = 0; m_last[m] = 0; m_perr[m] = 0; m_cnt[m] = 0;
      end
      forever begin
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            cv = 0; cd = 0;
            if (m_locked[m]) begin
               cd = m_owner[m];
               cv = cd ? data_req : instr_req;
            end else if (m_cnt[m] < MAXO) begin
               if (data_req && instr_req) begin
                  cv = 1;
                  cd = (m == 0) ? 1'b1 : !m_last[m];
               end else if (data_req || instr_req) begin
                  cv = 1;
                  cd = data_req;
               end
            end
            ew = 0; ebe = 0; eaddr = 0; ewd = 0; eint = 0;
            if (cv && cd) begin
               ew = data_we; ebe = data_be; eaddr = data_addr; ewd = data_wdata; eint = data_wintg;
            end else if (cv) begin
               ebe = 4'hF; eaddr = instr_addr;
            end
            gnt = cv && bus_gnt;
            has = m_cnt[m] > 0;
            irv = bus_rvalid && has && !m_q[m][0];
            drv = bus_rvalid && has && m_q[m][0];
            if (chk_en) begin
               p = $sformatf("dut%0d", m);
               check({p, " bus_req"}, bus_req[m], cv);
               check({p, " bus_fields"}, {bus_we[m], bus_be[m], bus_addr[m]}, {ew, ebe, eaddr});
               check({p, " bus_wdata"}, {bus_wintg[m], bus_wdata[m]}, {eint, ewd});
               check({p, " gnts"}, {instr_gnt[m], data_gnt[m]}, {gnt && !cd, gnt && cd});
               check({p, " rvalids"}, {instr_rvalid[m], data_rvalid[m]}, {irv, drv});
               check({p, " errs"}, {instr_err[m], data_err[m]}, {irv && bus_err, drv && bus_err});
               check({p, " rdata"}, {instr_rdata[m], data_rdata[m]}, {bus_rdata, bus_rdata});
               check({p, " rintg"}, {instr_rintg[m], data_rintg[m]}, {bus_rintg, bus_rintg});
               check({p, " outstanding"}, outst[m], m_cnt[m]);
               check({p, " protocol_err"}, perr[m], m_perr[m]);
               if (gnt) $display("t=%0t %s grant %s addr=%h", $time, p, cd ? "data" : "instr", eaddr);
               if (irv || drv) $display("t=%0t %s response -> %s err=%0d", $time, p, drv ? "data" : "instr", bus_err);
            end
            if (rst) begin
               m_locked[m] = 0; m_last[m] = 0; m_perr[m] = 0; m_cnt[m] = 0;
            end else begin
               if (bus_rvalid) begin
                  if (has) begin
                     for (int k = 0; k < 3; k++) m_q[m][k] = m_q[m][k+1];
                     m_cnt[m]--;
                  end else begin
                     m_perr[m] = 1;
                  end
               end
               if (gnt) begin
                  m_q[m][m_cnt[m]] = cd;
                  m_cnt[m]++;
                  m_last[m] = cd;
               end
               m_locked[m] = cv && !gnt;
               m_owner[m] = cd;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      instr_req = 0; data_req = 0; data_we = 0; data_be = 0;
      bus_gnt = 0; bus_rvalid = 0; bus_err = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      tick();
      tick();
      chk_en = 1;
      rst = 0;

      // Reset state with all requests low
      @(negedge clk);
      check("reset outstanding", outst[0], 2'd0);
      check("reset protocol_err", perr[0], 1'b0);
      check("reset bus_be", bus_be[0], 4'h0);
      tick();

      // Data write granted in cycle 0, response in cycle 2
      data_req = 1; data_we = 1; data_be = 4'h3; data_addr = 32'h100;
      data_wdata = 32'hDEADBEEF; data_wintg = 7'h55; bus_gnt = 1;
      @(negedge clk);
      check("wr data_gnt", data_gnt[0], 1'b1);
      check("wr bus_addr", bus_addr[0], 32'h100);
      check("wr bus_wdata", bus_wdata[0], 32'hDEADBEEF);
      tick();
      idle_inputs();
      @(negedge clk);
      check("wr outstanding", outst[0], 2'd1);
      tick();
      bus_rvalid = 1; bus_rdata = 32'h12345678; bus_rintg = 7'h2A;
      @(negedge clk);
      check("wr data_rvalid", data_rvalid[0], 1'b1);
      check("wr instr_rvalid", instr_rvalid[0], 1'b0);
      check("wr rdata", data_rdata[0], 32'h12345678);
      tick();
      idle_inputs();
      @(negedge clk);
      check("wr outstanding drained", outst[0], 2'd0);
      tick();

      // Contention, always granted, one response per cycle
      do_reset();
      for (int i = 0; i < 4; i++) begin
         instr_req = 1; instr_addr = 32'h1000 + 32'(i * 4);
         data_req = 1; data_we = 0; data_be = 4'hF; data_addr = 32'h400 + 32'(i * 4);
         bus_gnt = 1; bus_rvalid = (i > 0); bus_rdata = 32'(i);
         @(negedge clk);
         check("pri data_gnt", data_gnt[0], 1'b1);
         check("rr data_gnt", data_gnt[1], (i % 2) == 0);
         check("rr instr_gnt", instr_gnt[1], (i % 2) == 1);
         tick();
      end

      // Held request: instr stalled 3 cycles, data arrives in cycle 1
      do_reset();
      instr_addr = 32'h2000; data_addr = 32'h300; data_we = 0; data_be = 4'hF;
      for (int i = 0; i < 5; i++) begin
         instr_req = (i <= 3); data_req = (i >= 1); bus_gnt = (i >= 3);
         @(negedge clk);
         if (i <= 3) begin
            check("hold bus_addr", bus_addr[0], 32'h2000);
            check("hold instr_gnt", instr_gnt[0], i == 3);
            check("hold data_gnt", data_gnt[0], 1'b0);
         end else begin
            check("hold data_gnt later", data_gnt[0], 1'b1);
            check("hold data addr", bus_addr[0], 32'h300);
         end
         tick();
      end

      // Full FIFO blocks requests; a pop unblocks only on the next cycle
      do_reset();
      instr_addr = 32'h3000;
      for (int i = 0; i < 6; i++) begin
         instr_req = 1; bus_gnt = 1; bus_rvalid = (i == 4);
         @(negedge clk);
         check("full bus_req", bus_req[0], (i < 2) || (i == 5));
         check("full instr_gnt", instr_gnt[1], (i < 2) || (i == 5));
         if (i == 3) check("full outstanding", outst[0], 2'd2);
         tick();
      end

      // Mixed order I, D, I with an error on the data response
      do_reset();
      for (int i = 0; i < 7; i++) begin
         idle_inputs();
         case (i)
            0: begin instr_req = 1; bus_gnt = 1; end
            1: begin data_req = 1; data_be = 4'hF; bus_gnt = 1; end
            2: begin bus_rvalid = 1; end
            3: begin instr_req = 1; bus_gnt = 1; end
            4: begin bus_rvalid = 1; bus_err = 1; end
            5: begin bus_rvalid = 1; end
            default: ;
         endcase
         @(negedge clk);
         case (i)
            2: check("mix rv1 instr", {instr_rvalid[0], data_rvalid[0]}, 2'b10);
            4: check("mix rv2 data err", {data_rvalid[0], data_err[0], instr_err[0]}, 3'b110);
            5: check("mix rv3 instr", {instr_rvalid[0], instr_err[0], data_err[0]}, 3'b100);
            6: check("mix drained", outst[1], 2'd0);
            default: ;
         endcase
         tick();
      end

      // Stray response with nothing outstanding
      idle_inputs();
      bus_rvalid = 1;
      @(negedge clk);
      check("stray rvalids", {instr_rvalid[0], data_rvalid[0]}, 2'b00);
      tick();
      bus_rvalid = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("stray protocol_err sticky", perr[0], 1'b1);
         tick();
      end
      do_reset();
      @(negedge clk);
      check("protocol_err cleared", perr[0], 1'b0);
      tick();

      // Reset while a transaction is outstanding; its late response is a protocol error
      data_req = 1; data_be = 4'hF; data_addr = 32'h500; bus_gnt = 1;
      tick();
      do_reset();
      bus_rvalid = 1;
      @(negedge clk);
      check("late rsp dropped", data_rvalid[0], 1'b0);
      tick();
      idle_inputs();
      @(negedge clk);
      check("late rsp protocol_err", perr[1], 1'b1);
      tick();

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
